// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and types for the register file.
// Contents: DATA_W/ADDR_W/NUM_REGS, rf_wr_e write codes, rf_addr_t, rf_data_t.
package rf_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  typedef enum logic [1:0] {
    RF_WR_NONE = 2'b00,
    RF_WR_WORD = 2'b01,
    RF_WR_LO   = 2'b10,
    RF_WR_HI   = 2'b11
  } rf_wr_e;
  typedef logic [ADDR_W-1:0] rf_addr_t;
  typedef logic [DATA_W-1:0] rf_data_t;
endpackage

// File: rtl/rf_write_merge.sv
// rf_write_merge: combinational merge of write data into the old register word.
// Ports: i_old (current word), i_wdata (write data), i_mode (rf_wr_e code),
//        o_new (word after the write; i_old when i_mode is RF_WR_NONE).
module rf_write_merge
  import rf_pkg::*;
(
  input  rf_data_t i_old,
  input  rf_data_t i_wdata,
  input  rf_wr_e   i_mode,
  output rf_data_t o_new
);
  localparam int H = DATA_W / 2;
  always_comb
    o_new = i_mode == RF_WR_WORD ? i_wdata :
            i_mode == RF_WR_LO   ? {i_old[DATA_W-1:H], i_wdata[H-1:0]} :
            i_mode == RF_WR_HI   ? {i_wdata[DATA_W-1:H], i_old[H-1:0]} :
            i_old;
endmodule

// File: rtl/register_file.sv
// register_file: 32x32 register file, two combinational reads, one synchronous write.
// Ports: clk, rst_n (async active-low, clears all registers), Read1/Read2 (read
//        addresses), WriteReg (write address), RegWrite (00 none, 01 word,
//        10 low half, 11 high half), WriteData, Data1/Data2 (read data).
// Option: define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module register_file
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [1:0]        RegWrite,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2
);
  rf_data_t r_regs [NUM_REGS];
  rf_data_t w_new;
  rf_wr_e   w_mode;
  logic     w_we;
  assign w_mode = rf_wr_e'(RegWrite);
  // Address 0 is never written, so it stays at its reset value of zero.
  assign w_we = w_mode != RF_WR_NONE && WriteReg != '0;
  rf_write_merge u_merge (
    .i_old   (r_regs[WriteReg]),
    .i_wdata (WriteData),
    .i_mode  (w_mode),
    .o_new   (w_new)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    else if (w_we)
      r_regs[WriteReg] <= w_new;
`ifdef RF_BYPASS_EN
  logic w_fwd;
  // Forwarding is gated by rst_n so reads return zero throughout reset.
  assign w_fwd = rst_n && w_we;
  assign Data1 = w_fwd && Read1 == WriteReg ? w_new : r_regs[Read1];
  assign Data2 = w_fwd && Read2 == WriteReg ? w_new : r_regs[Read2];
`else
  assign Data1 = r_regs[Read1];
  assign Data2 = r_regs[Read2];
`endif
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed self-checking bench for register_file.
module tb_register_file;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Read1, Read2, WriteReg;
  logic [1:0]  RegWrite;
  logic [31:0] WriteData;
  logic [31:0] Data1, Data2;
  int n_checks = 0;
  int n_errors = 0;
  register_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Read1     (Read1),
    .Read2     (Read2),
    .WriteReg  (WriteReg),
    .RegWrite  (RegWrite),
    .WriteData (WriteData),
    .Data1     (Data1),
    .Data2     (Data2)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [1:0] m, input logic [31:0] d);
    @(negedge clk);
    WriteReg = a;
    RegWrite = m;
    WriteData = d;
    @(posedge clk);
    #1;
    RegWrite = 2'b00;
  endtask
  initial begin
    rst_n = 1'b0;
    Read1 = 5'd5;
    Read2 = 5'd10;
    WriteReg = 5'd5;
    RegWrite = 2'b01;
    WriteData = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    check("in_reset_d1", Data1, 32'h0);
    check("in_reset_d2", Data2, 32'h0);
    RegWrite = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_d1", Data1, 32'h0);
    check("post_reset_d2", Data2, 32'h0);
    wr(5'd5, 2'b01, 32'h55555555);
    check("word_r5", Data1, 32'h55555555);
    wr(5'd10, 2'b01, 32'hAAAAAAAA);
    check("word_r10", Data2, 32'hAAAAAAAA);
    check("r5_kept", Data1, 32'h55555555);
    Read1 = 5'd10;
    #1;
    check("same_reg_both", Data1, Data2);
    check("same_reg_val", Data1, 32'hAAAAAAAA);
    Read1 = 5'd5;
    wr(5'd5, 2'b01, 32'h0);
    wr(5'd10, 2'b01, 32'h0);
    check("zero_r5", Data1, 32'h0);
    check("zero_r10", Data2, 32'h0);
    Read1 = 5'd0;
    wr(5'd0, 2'b01, 32'hFFFFFFFF);
    check("r0_word", Data1, 32'h0);
    wr(5'd0, 2'b10, 32'hFFFFFFFF);
    check("r0_lo", Data1, 32'h0);
    wr(5'd0, 2'b11, 32'hFFFFFFFF);
    check("r0_hi", Data1, 32'h0);
    Read1 = 5'd7;
    wr(5'd7, 2'b01, 32'h12345678);
    check("r7_init", Data1, 32'h12345678);
    wr(5'd7, 2'b10, 32'h0000BEEF);
    check("r7_lo", Data1, 32'h1234BEEF);
    wr(5'd7, 2'b11, 32'hCAFE0000);
    check("r7_hi", Data1, 32'hCAFEBEEF);
    wr(5'd7, 2'b00, 32'hDEADDEAD);
    check("r7_none", Data1, 32'hCAFEBEEF);
    wr(5'd7, 2'b10, 32'h9999AAAA);
    check("r7_lo_mask", Data1, 32'hCAFEAAAA);
    wr(5'd7, 2'b11, 32'h1111FFFF);
    check("r7_hi_mask", Data1, 32'h1111AAAA);
    wr(5'd5, 2'b01, 32'h55555555);
    @(negedge clk);
    Read1 = 5'd5;
    Read2 = 5'd7;
    WriteReg = 5'd5;
    RegWrite = 2'b01;
    WriteData = 32'hAAAAAAAA;
    #1;
`ifdef RF_BYPASS_EN
    check("rdw_before", Data1, 32'hAAAAAAAA);
`else
    check("rdw_before", Data1, 32'h55555555);
`endif
    check("rdw_other_port", Data2, 32'h1111AAAA);
    @(posedge clk);
    #1;
    RegWrite = 2'b00;
    check("rdw_after", Data1, 32'hAAAAAAAA);
    @(negedge clk);
    Read2 = 5'd7;
    WriteReg = 5'd7;
    RegWrite = 2'b11;
    WriteData = 32'h7777_0000;
    #1;
`ifdef RF_BYPASS_EN
    check("rdw_hi_before", Data2, 32'h7777AAAA);
`else
    check("rdw_hi_before", Data2, 32'h1111AAAA);
`endif
    @(posedge clk);
    #1;
    RegWrite = 2'b00;
    check("rdw_hi_after", Data2, 32'h7777AAAA);
    wr(5'd10, 2'b01, 32'h13572468);
    @(negedge clk);
    Read1 = 5'd5;
    Read2 = 5'd10;
    #1;
    check("pre_arst_d1", Data1, 32'hAAAAAAAA);
    check("pre_arst_d2", Data2, 32'h13572468);
    WriteReg = 5'd10;
    RegWrite = 2'b01;
    WriteData = 32'hFFFF0000;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_d1", Data1, 32'h0);
    check("arst_d2", Data2, 32'h0);
    @(posedge clk);
    #1;
    check("arst_write_lost", Data2, 32'h0);
    @(negedge clk);
    RegWrite = 2'b00;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_release_d1", Data1, 32'h0);
    check("arst_release_d2", Data2, 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
